rr_arbiter: RTL
===============

// Module: rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one WIDTH-bit downstream channel between 2**N requesters.
//  Picks a requester, steers its data through mux_gen, and registers the beat into a
//  single output stage with a valid/ready handshake.
//  Sits in front of any shared unit (bus port, writeback path) fed by several producers.
// PARAMETERS
//  WIDTH  32  data width per requester
//  N      2   select width; requester count = 2**N (N>=1)
// PORTS
//  clk        in   1            clock; all state changes on rising edge
//  rst        in   1            synchronous, active-high reset
//  req_valid  in   2**N         per-requester beat valid
//  req_data   in   WIDTH x 2**N unpacked array, per-requester data
//  req_last   in   2**N         last beat of packet (used only with RR_ARB_HOLD_EN)
//  req_ready  out  2**N         one-hot accept pulse; beat taken when valid&ready
//  out_valid  out  1            output beat valid
//  out_data   out  WIDTH        output beat data
//  out_sel    out  N            index of requester that owns out_data
//  out_ready  in   1            downstream accept
// BEHAVIOUR
//  Reset (rst=1 at edge): state=ARB_IDLE, ptr=0, lock=0, out_valid=0, out_data=0, out_sel=0.
//   req_ready=0 while rst=1. A held beat is discarded; no req_ready pulse during reset.
//  Slot free = (state==ARB_IDLE) | (out_valid & out_ready).
//  Pick: first i with req_valid[i], scanning ptr, ptr+1, ... wrapping mod 2**N.
//  Accept: slot free & any req_valid -> req_ready[g]=1 combinationally, same cycle, one-hot.
//   Next edge: out_data<=req_data[g], out_sel<=g, out_valid<=1, ptr<=(g+1) mod 2**N,
//   state<=ARB_BUSY.
//  ARB_BUSY: out_data/out_sel stable while out_valid & !out_ready. req_ready=0.
//  ARB_BUSY & out_ready & no req_valid -> out_valid<=0, state<=ARB_IDLE.
//  ARB_BUSY & out_ready & req_valid -> back-to-back accept, stay ARB_BUSY.
//   Throughput 1 beat/cycle. Latency request->out_valid = 1 cycle.
//  req_valid may drop before grant without penalty. ptr moves only on accept.
//  ptr wraps 2**N-1 -> 0. Lone requester is re-granted every free slot.
//  req_data sampled only in the accept cycle. Data path is mux_gen indexed by g.
// CONFIGURATION
//  RR_ARB_HOLD_EN defined:
//   - Accepting g with req_last[g]=0 sets lock=1 and lock_id=g.
//   - While lock=1, the pick considers only lock_id. Other requesters wait even if valid.
//   - Accepting lock_id with req_last=1 clears lock. ptr advances as normal.
//  RR_ARB_HOLD_EN undefined:
//   - req_last is ignored and lock logic is absent.
//   - Every beat is arbitrated independently.
// STRUCTURE
//  arb_pkg:
//   - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t.
//   - function rr_next(ptr, n) for wrap increment.
//  Sub-module rr_pick (combinational):
//   - inputs: req vector, ptr.
//   - outputs: grant index g, any_req.
//   - implemented as a rotate, a fixed-priority find-first, and an un-rotate.
//  rr_arbiter holds the FSM, ptr, lock, output register and mux_gen instance.
// TESTING
//  1. Reset with all req_valid=1, hold rst 3 cycles -> req_ready=0, out_valid=0, out_*=0.
//     First grant is to req 0.
//  2. N=2, all 4 valid, out_ready=1, data=i*0x11 ->
//     out_sel 0,1,2,3,0 on consecutive cycles; out_data 0x00,0x11,0x22,0x33,0x00.
//  3. Only req 2 valid, out_ready=0 for 5 cycles ->
//     one req_ready pulse, out_data=0x22 held stable, no second accept until out_ready=1.
//  4. ptr=3 after grant to 2; req 1 and 3 valid -> grant 3, then 1 (wrap).
//     Req 1 dropping valid before its grant gives no pulse.
//  5. Assert rst while ARB_BUSY with out_valid=1 ->
//     out_valid=0 next cycle, ptr=0, no beat is lost or duplicated after release.
//  6. RR_ARB_HOLD_EN: req 1 sends 3 beats (last on 3rd), req 0 valid throughout ->
//     out_sel 1,1,1,0. Without the macro -> 1,0,1,0 pattern.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

    // Output-slot state: empty, or holding a beat for downstream.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Wrapping increment of a requester index over 2**n requesters.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1) % (32'd1 << n);
    endfunction

endpackage

// File: rtl/mux_gen.sv
// Data steering mux: selects one of 2**N WIDTH-bit inputs.
module mux_gen #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 2
) (
    input  logic [WIDTH-1:0] i_data [1<<N],
    input  logic [N-1:0]     i_sel,
    output logic [WIDTH-1:0] o_data
);

    // Index the selected requester's data.
    always_comb begin
        o_data = i_data[i_sel];
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate the request vector so the
// pointer lands on bit 0, take the lowest set bit, then un-rotate.
module rr_pick #(
    parameter int unsigned N = 2
) (
    input  logic [(1<<N)-1:0] i_req,
    input  logic [N-1:0]      i_ptr,
    output logic [N-1:0]      o_grant,
    output logic              o_any
);

    localparam int unsigned R = 1 << N;

    logic [R-1:0] w_rot;
    logic [N-1:0] w_idx;

    // Rotate requests so the current pointer sits at bit 0.
    always_comb begin
        w_rot = '0;
        for (int unsigned i = 0; i < R; i++) begin
            w_rot[N'(i)] = i_req[N'(i) + i_ptr];
        end
    end

    // Fixed-priority find-first: lowest set bit of the rotated vector wins.
    always_comb begin
        w_idx = '0;
        for (int unsigned i = R; i > 0; i--) begin
            if (w_rot[N'(i - 1)]) begin
                w_idx = N'(i - 1);
            end
        end
    end

    // Un-rotate the index back to requester numbering (wraps in N bits).
    always_comb begin
        o_any   = |i_req;
        o_grant = w_idx + i_ptr;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: shares one WIDTH-bit registered output stage
// (valid/ready) between 2**N requesters.
// Optional packet hold is enabled by defining RR_ARB_HOLD_EN: once a
// requester is accepted with req_last=0 it keeps the channel until it
// sends a beat with req_last=1.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [(1<<N)-1:0]    req_valid,
    input  logic [WIDTH-1:0]     req_data [1<<N],
    input  logic [(1<<N)-1:0]    req_last,
    output logic [(1<<N)-1:0]    req_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [N-1:0]         out_sel,
    input  logic                 out_ready
);

    localparam int unsigned R = 1 << N;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [N-1:0]     r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [N-1:0]     r_out_sel;

    logic [R-1:0]     w_req_eff;
    logic [N-1:0]     w_grant;
    logic             w_any;
    logic             w_slot_free;
    logic             w_accept;
    logic [WIDTH-1:0] w_mux;

`ifdef RR_ARB_HOLD_EN
    logic         r_lock;
    logic [N-1:0] r_lock_id;

    // While locked, only the packet owner is visible to the picker.
    always_comb begin
        w_req_eff = r_lock ? (req_valid & (R'(1) << r_lock_id)) : req_valid;
    end

    // Lock on a non-last beat, release on the owner's last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_accept) begin
            if (!req_last[w_grant]) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_grant;
            end else begin
                r_lock    <= 1'b0;
            end
        end
    end
`else
    logic w_unused_last;

    // Every beat is arbitrated independently; req_last has no effect.
    always_comb begin
        w_req_eff     = req_valid;
        w_unused_last = ^req_last;
    end
`endif

    rr_pick #(.N(N)) u_pick (
        .i_req   (w_req_eff),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    mux_gen #(.WIDTH(WIDTH), .N(N)) u_mux_gen (
        .i_data (req_data),
        .i_sel  (w_grant),
        .o_data (w_mux)
    );

    // Accept decision and one-hot ready pulse; nothing is taken during reset.
    always_comb begin
        w_slot_free = (r_state == ARB_IDLE) | (r_out_valid & out_ready);
        w_accept    = w_slot_free & w_any & ~rst;
        req_ready   = w_accept ? (R'(1) << w_grant) : '0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: any accept fills the slot, a drain with no accept empties it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_accept) w_state_nxt = ARB_BUSY;
            end
            ARB_BUSY: begin
                if (w_accept)       w_state_nxt = ARB_BUSY;
                else if (out_ready) w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Output stage and pointer: load on accept, drop valid on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_out_sel   <= w_grant;
            r_ptr       <= N'(rr_next(32'(w_grant), N));
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Drive registered outputs.
    always_comb begin
        out_valid = r_out_valid;
        out_data  = r_out_data;
        out_sel   = r_out_sel;
    end

endmodule
